dec_pipe: RTL

Pipelined, parametrised decoder stage with valid/ready flow control on both sides.
- Each accepted index is expanded to an N-bit vector in one of three modes: one-hot, thermometer, or inverted one-hot (mask).
- The result is held in a registered 2-entry skid buffer, so back-pressure never drops or duplicates a decode.
- Sits between an issue/select stage and a wide vector consumer (e.g. wakeup or allocation masks), where the decode must be registered for timing.

---
 rtl/dec_pkg.sv | 36 +++
 rtl/dec_pipe_skid.sv | 80 ++++++++
 rtl/dec_pipe.sv | 62 ++++++
 3 files changed

// File: rtl/dec_pkg.sv
// Shared types and the per-bit decode function for the dec_pipe stage.
// Optional build macro used by dec_pipe: DEC_PIPE_RANGE_CHK_EN.
package dec_pkg;

  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'b00,
    MODE_THERM  = 2'b01,
    MODE_MASK   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  // Occupancy of the output register plus skid entry.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_TWO   = 2'b10
  } occ_t;

  // One output bit of the decode: bit i of f(x, mode). Written per bit so the
  // caller can expand it with a generate loop for any width. An index beyond
  // the vector width falls out naturally: no onehot bit matches, every therm
  // bit satisfies i <= x, and every mask bit is set.
  function automatic logic dec_f(input int unsigned x, input mode_t mode,
                                 input int unsigned i);
    logic b;
    b = 1'b0;
    case (mode)
      MODE_ONEHOT: b = (x == i);
      MODE_THERM:  b = (i <= x);
      MODE_MASK:   b = (x != i);
      default:     b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dec_pipe_skid.sv
// Generic two-entry registered skid buffer: output register plus one skid
// entry, with a registered upstream ready that never looks at downstream ready.
module dec_pipe_skid
  import dec_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          in_vld_i,
  input  logic [DW-1:0] in_data_i,
  output logic          in_rdy_o,
  output logic          out_vld_o,
  output logic [DW-1:0] out_data_o,
  input  logic          out_rdy_i
);

  occ_t          state_q, state_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [DW-1:0] skid_data_q, skid_data_d;
  logic          accept, consume;

  // Ready and valid come straight from the occupancy register.
  assign in_rdy_o   = (state_q != OCC_TWO);
  assign out_vld_o  = (state_q != OCC_EMPTY);
  assign out_data_o = out_data_q;

  assign accept  = in_vld_i && (state_q != OCC_TWO);
  assign consume = out_rdy_i && (state_q != OCC_EMPTY);

  // Next occupancy and data moves; data only loads when a beat lands there.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    skid_data_d = skid_data_q;
    case (state_q)
      OCC_EMPTY: begin
        if (accept) begin
          state_d    = OCC_ONE;
          out_data_d = in_data_i;
        end
      end
      OCC_ONE: begin
        if (accept && consume) begin
          out_data_d = in_data_i;
        end else if (accept) begin
          state_d     = OCC_TWO;
          skid_data_d = in_data_i;
        end else if (consume) begin
          // Output data is left as-is; only the valid drops.
          state_d = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (consume) begin
          state_d     = OCC_ONE;
          out_data_d  = skid_data_q;
          skid_data_d = '0;
        end
      end
      default: begin
        state_d = OCC_EMPTY;
      end
    endcase
  end

  // Occupancy and data registers; reset empties both entries immediately.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= OCC_EMPTY;
      out_data_q  <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      skid_data_q <= skid_data_d;
    end
  end

endmodule

// File: rtl/dec_pipe.sv
// Pipelined index decoder (one-hot / thermometer / mask) with a registered
// two-entry skid buffer on the output. Defining DEC_PIPE_RANGE_CHK_EN adds
// o_err, flagging an out-of-range index or reserved mode, carried with its data.
module dec_pipe
  import dec_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         i_vld,
  input  logic [W-1:0] i_x,
  input  logic [1:0]   i_mode,
  output logic         o_rdy,
  output logic         o_vld,
  output logic [N-1:0] o_y,
  input  logic         i_rdy
`ifdef DEC_PIPE_RANGE_CHK_EN
  ,
  output logic         o_err
`endif
);

  logic [N-1:0] dec_y;

  // Combinational decode ahead of the registers, one bit per generate slice.
  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_dec
    assign dec_y[gi] = dec_f(32'(i_x), mode_t'(i_mode), gi);
  end

`ifdef DEC_PIPE_RANGE_CHK_EN
  localparam int DW = N + 1;
  logic          dec_err;
  logic [DW-1:0] in_data, out_data;

  assign dec_err      = (32'(i_x) >= N) || (mode_t'(i_mode) == MODE_RSVD);
  assign in_data      = {dec_err, dec_y};
  assign {o_err, o_y} = out_data;
`else
  localparam int DW = N;
  logic [DW-1:0] in_data, out_data;

  assign in_data = dec_y;
  assign o_y     = out_data;
`endif

  dec_pipe_skid #(
    .DW(DW)
  ) u_skid (
    .clk        (clk),
    .arst_n     (arst_n),
    .in_vld_i   (i_vld),
    .in_data_i  (in_data),
    .in_rdy_o   (o_rdy),
    .out_vld_o  (o_vld),
    .out_data_o (out_data),
    .out_rdy_i  (i_rdy)
  );

endmodule
